// File: rtl/frame_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frame_arb_pkg
// Description : Shared types and constants for the two-source AXIS frame
//               arbiter (FSM state, source index, round-robin helper).
// Revision    : 1.0 - initial release
// ============================================================================
package frame_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic [0:0] src_idx_t;

    localparam src_idx_t c_src0           = 1'b0;
    localparam src_idx_t c_src1           = 1'b1;
    // s00 must win the first contention after reset, so last-grant starts at s01
    localparam src_idx_t c_last_grant_rst = c_src1;

    function automatic src_idx_t rr_pick(input logic [1:0] req, input src_idx_t last_grant);
        src_idx_t pick;
        if (&req) begin
            pick = ~last_grant;
        end else if (req[1]) begin
            pick = c_src1;
        end else begin
            pick = c_src0;
        end
        return pick;
    endfunction

endpackage : frame_arb_pkg
`default_nettype wire

// File: rtl/frame_arb_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frame_arb_rr
// Description : Two-way round-robin picker; the source that did not win last
//               time is preferred when both request.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_arb_rr
    import frame_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  src_idx_t   i_last_grant,
    output src_idx_t   o_grant
);

    assign o_grant = rr_pick(i_req, i_last_grant);

endmodule : frame_arb_rr
`default_nettype wire

// File: rtl/axis_frame_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axis_frame_arbiter
// Description : Merges two AXI-Stream frame sources onto one master port,
//               switching only at frame boundaries (round robin).
//               Optional per-source frame counters: FRAME_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_arbiter
    import frame_arb_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_STAT_WIDTH       = 16
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [1:0]                      src_en,

    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                            s00_axis_tvalid,
    input  logic                            s00_axis_tlast,
    output logic                            s00_axis_tready,

    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                            s01_axis_tvalid,
    input  logic                            s01_axis_tlast,
    output logic                            s01_axis_tready,

    output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                            m00_axis_tvalid,
    output logic                            m00_axis_tlast,
    input  logic                            m00_axis_tready,
    output logic                            m00_axis_tdest,

    output logic                            busy
`ifdef FRAME_ARB_STATS_EN
    ,
    output logic [C_STAT_WIDTH-1:0]         frame_cnt0,
    output logic [C_STAT_WIDTH-1:0]         frame_cnt1
`endif
);

    state_t     r_state;
    state_t     w_state_next;
    src_idx_t   r_grant;
    src_idx_t   w_grant_next;
    src_idx_t   r_last_grant;
    src_idx_t   w_last_grant_next;
    src_idx_t   w_pick;
    logic [1:0] w_req;
    logic       w_fire_last;

    assign w_req = {s01_axis_tvalid & src_en[1], s00_axis_tvalid & src_en[0]};

    frame_arb_rr u_rr (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick)
    );

    // Frame ends on the accepted tlast beat of the granted source
    assign w_fire_last = (r_state == BUSY) & m00_axis_tvalid & m00_axis_tready & m00_axis_tlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_grant      <= c_src0;
            r_last_grant <= c_last_grant_rst;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_next = BUSY;
                    w_grant_next = w_pick;
                end
            end
            BUSY: begin
                if (w_fire_last) begin
                    w_state_next      = IDLE;
                    w_last_grant_next = r_grant;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        m00_axis_tdata  = '0;
        m00_axis_tstrb  = '0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        m00_axis_tdest  = 1'b0;
        s00_axis_tready = 1'b0;
        s01_axis_tready = 1'b0;
        busy            = 1'b0;
        if (r_state == BUSY) begin
            busy           = 1'b1;
            m00_axis_tdest = r_grant;
            if (r_grant == c_src1) begin
                m00_axis_tdata  = s01_axis_tdata;
                m00_axis_tstrb  = s01_axis_tstrb;
                m00_axis_tvalid = s01_axis_tvalid;
                m00_axis_tlast  = s01_axis_tlast;
                s01_axis_tready = m00_axis_tready;
            end else begin
                m00_axis_tdata  = s00_axis_tdata;
                m00_axis_tstrb  = s00_axis_tstrb;
                m00_axis_tvalid = s00_axis_tvalid;
                m00_axis_tlast  = s00_axis_tlast;
                s00_axis_tready = m00_axis_tready;
            end
        end
    end

`ifdef FRAME_ARB_STATS_EN
    logic [C_STAT_WIDTH-1:0] r_frame_cnt0;
    logic [C_STAT_WIDTH-1:0] r_frame_cnt1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_frame_cnt0 <= '0;
            r_frame_cnt1 <= '0;
        end else if (w_fire_last) begin
            if (r_grant == c_src1) begin
                r_frame_cnt1 <= r_frame_cnt1 + C_STAT_WIDTH'(1);
            end else begin
                r_frame_cnt0 <= r_frame_cnt0 + C_STAT_WIDTH'(1);
            end
        end
    end

    assign frame_cnt0 = r_frame_cnt0;
    assign frame_cnt1 = r_frame_cnt1;
`else
    logic [C_STAT_WIDTH-1:0] w_stat_unused;
    assign w_stat_unused = '0;
`endif

endmodule : axis_frame_arbiter
`default_nettype wire

// File: tb/tb_axis_frame_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_arbiter
// Description : Self-checking bench for axis_frame_arbiter against a
//               frame-level reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_arbiter;

    localparam int W  = 32;
    localparam int SW = 2;

    typedef struct packed {
        logic           last;
        logic [W/8-1:0] strb;
        logic [W-1:0]   data;
    } beat_t;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [1:0]     src_en;
    logic [W-1:0]   s00_axis_tdata, s01_axis_tdata, m00_axis_tdata;
    logic [W/8-1:0] s00_axis_tstrb, s01_axis_tstrb, m00_axis_tstrb;
    logic           s00_axis_tvalid, s01_axis_tvalid, m00_axis_tvalid;
    logic           s00_axis_tlast, s01_axis_tlast, m00_axis_tlast;
    logic           s00_axis_tready, s01_axis_tready, m00_axis_tready;
    logic           m00_axis_tdest;
    logic           busy;
`ifdef FRAME_ARB_STATS_EN
    logic [SW-1:0]  frame_cnt0, frame_cnt1;
`endif

    axis_frame_arbiter #(
        .C_AXIS_TDATA_WIDTH (W),
        .C_STAT_WIDTH       (SW)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .src_en          (src_en),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tstrb  (s00_axis_tstrb),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tlast  (s00_axis_tlast),
        .s00_axis_tready (s00_axis_tready),
        .s01_axis_tdata  (s01_axis_tdata),
        .s01_axis_tstrb  (s01_axis_tstrb),
        .s01_axis_tvalid (s01_axis_tvalid),
        .s01_axis_tlast  (s01_axis_tlast),
        .s01_axis_tready (s01_axis_tready),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tstrb  (m00_axis_tstrb),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tlast  (m00_axis_tlast),
        .m00_axis_tready (m00_axis_tready),
        .m00_axis_tdest  (m00_axis_tdest),
        .busy            (busy)
`ifdef FRAME_ARB_STATS_EN
        ,
        .frame_cnt0      (frame_cnt0),
        .frame_cnt1      (frame_cnt1)
`endif
    );

    always #5 aclk = ~aclk;

    // Source frame queues and frame-level model state
    beat_t q0[$];
    beat_t q1[$];
    int    owner;        // -1 when no frame is locked
    int    last_owner;
    int    frames[2];
    logic [1:0] hold;
    logic  gap_en;
    int    rdy_mode;     // 0: always ready, 1: toggle, 2: random
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t head(input int s);
        beat_t b;
        b = '0;
        if (s == 0 && q0.size() > 0) b = q0[0];
        if (s == 1 && q1.size() > 0) b = q1[0];
        return b;
    endfunction

    task automatic push_frame(input int s, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = $urandom;
            b.strb = 4'($urandom);
            b.last = (k == len - 1);
            if (s == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
    endtask

    task automatic drive();
        beat_t b0, b1;
        b0 = head(0);
        b1 = head(1);
        s00_axis_tvalid = (q0.size() > 0) && !hold[0];
        {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata} = b0;
        s01_axis_tvalid = (q1.size() > 0) && !hold[1];
        {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata} = b1;
    endtask

    // One clock: drive at negedge, check #1 later, advance the model at posedge
    task automatic cycle();
        beat_t hb;
        logic  v;
        case (rdy_mode)
            1:       m00_axis_tready = ~m00_axis_tready;
            2:       m00_axis_tready = ($urandom_range(0, 2) != 0);
            default: m00_axis_tready = 1'b1;
        endcase
        for (int i = 0; i < 2; i++) hold[i] = gap_en && ($urandom_range(0, 3) == 0);
        drive();
        #1;
        v  = 1'b0;
        hb = '0;
        if (owner < 0) begin
            check("busy_idle",      busy, 0);
            check("m_tvalid_idle",  m00_axis_tvalid, 0);
            check("tdest_idle",     m00_axis_tdest, 0);
            check("s00_tready_idle", s00_axis_tready, 0);
            check("s01_tready_idle", s01_axis_tready, 0);
        end else begin
            hb = head(owner);
            v  = (owner == 0) ? s00_axis_tvalid : s01_axis_tvalid;
            check("busy",       busy, 1);
            check("tdest",      m00_axis_tdest, 64'(owner));
            check("m_tvalid",   m00_axis_tvalid, v);
            check("s00_tready", s00_axis_tready, (owner == 0) ? m00_axis_tready : 1'b0);
            check("s01_tready", s01_axis_tready, (owner == 1) ? m00_axis_tready : 1'b0);
            if (v) begin
                check("m_tdata", m00_axis_tdata, hb.data);
                check("m_tstrb", m00_axis_tstrb, hb.strb);
                check("m_tlast", m00_axis_tlast, hb.last);
            end
        end
`ifdef FRAME_ARB_STATS_EN
        check("frame_cnt0", frame_cnt0, SW'(frames[0]));
        check("frame_cnt1", frame_cnt1, SW'(frames[1]));
`endif
        @(posedge aclk);
        if (owner >= 0) begin
            if (v && m00_axis_tready) begin
                if (owner == 0) void'(q0.pop_front());
                else            void'(q1.pop_front());
                if (hb.last) begin
                    frames[owner]++;
                    last_owner = owner;
                    owner      = -1;
                end
            end
        end else begin
            if (s00_axis_tvalid && src_en[0] && s01_axis_tvalid && src_en[1])
                owner = 1 - last_owner;
            else if (s00_axis_tvalid && src_en[0])
                owner = 0;
            else if (s01_axis_tvalid && src_en[1])
                owner = 1;
        end
        @(negedge aclk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        check("rst_busy",       busy, 0);
        check("rst_m_tvalid",   m00_axis_tvalid, 0);
        check("rst_tdest",      m00_axis_tdest, 0);
        check("rst_s00_tready", s00_axis_tready, 0);
        check("rst_s01_tready", s01_axis_tready, 0);
        q0.delete();
        q1.delete();
        owner      = -1;
        last_owner = 1;
        frames[0]  = 0;
        frames[1]  = 0;
`ifdef FRAME_ARB_STATS_EN
        check("rst_frame_cnt0", frame_cnt0, 0);
        check("rst_frame_cnt1", frame_cnt1, 0);
`endif
        drive();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && owner < 0) && k < budget) begin
            cycle();
            k++;
        end
        check("drain_done", (q0.size() == 0 && q1.size() == 0 && owner < 0), 1);
        cycle();
    endtask

    initial begin
        src_en          = 2'b11;
        m00_axis_tready = 1'b1;
        hold            = 2'b00;
        gap_en          = 1'b0;
        rdy_mode        = 0;
        owner           = -1;
        last_owner      = 1;
        drive();
        @(negedge aclk);
        do_reset();
        cycle();

        // Single 4-beat frame from s00
        push_frame(0, 4);
        drain(50);

        // Simultaneous 3-beat frames, then a second contention
        push_frame(0, 3);
        push_frame(1, 3);
        drain(50);
        push_frame(0, 2);
        push_frame(1, 2);
        drain(50);

        // Master backpressure toggling 1,0,1,0
        m00_axis_tready = 1'b0;
        rdy_mode = 1;
        push_frame(1, 4);
        push_frame(0, 3);
        drain(80);
        rdy_mode = 0;

        // Enable switched mid-frame
        src_en = 2'b01;
        push_frame(0, 4);
        push_frame(1, 4);
        cycle();
        cycle();
        src_en = 2'b10;
        drain(50);
        src_en = 2'b11;

        // Reset on beat 2 of a 5-beat frame, then contention goes to s00
        push_frame(0, 5);
        push_frame(1, 2);
        cycle();
        cycle();
        drive();
        do_reset();
        push_frame(0, 3);
        push_frame(1, 3);
        drain(50);

        // Five frames from s01 (counter wrap with 2-bit stats)
        for (int f = 0; f < 5; f++) push_frame(1, 1 + f % 3);
        drain(100);

        // Random traffic with valid gaps, backpressure and enable changes
        gap_en   = 1'b1;
        rdy_mode = 2;
        for (int c = 0; c < 600; c++) begin
            if (q0.size() == 0 && $urandom_range(0, 3) == 0) push_frame(0, $urandom_range(1, 6));
            if (q1.size() == 0 && $urandom_range(0, 3) == 0) push_frame(1, $urandom_range(1, 6));
            if (c % 40 == 39) src_en = 2'($urandom);
            cycle();
        end
        src_en = 2'b11;
        drain(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_axis_frame_arbiter
`default_nettype wire

// File: doc/axis_frame_arbiter.md
AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 Parameter C_AXIS_TDATA_WIDTH, default 32, tdata width of both slave ports and the master port.
REQ-002 Parameter C_STAT_WIDTH, default 16, width of each frame statistics counter.
REQ-003 aclk  in  1  single clock for all ports.
REQ-004 aresetn  in  1  reset, asynchronous, active-low.
REQ-005 src_en  in  2  per-source enable; bit i gates new grants to s0i.
REQ-006 s00_axis_tdata/tstrb/tvalid/tlast  in  W/W/8/1/1  source 0 stream; s00_axis_tready  out  1.
REQ-007 s01_axis_tdata/tstrb/tvalid/tlast  in  W/W/8/1/1  source 1 stream; s01_axis_tready  out  1.
REQ-008 m00_axis_tdata/tstrb/tvalid/tlast  out  W/W/8/1/1  merged stream; m00_axis_tready  in  1.
REQ-009 m00_axis_tdest  out  1  index of the source owning the current frame.
REQ-010 busy  out  1  high while a frame is locked to a source.
REQ-011 frame_cnt0, frame_cnt1  out  C_STAT_WIDTH  frames forwarded per source (present only with the stats macro).

Function
REQ-012 The block SHALL merge two AXIS frame sources onto one master port, switching sources only at frame boundaries.
REQ-013 The FSM SHALL have two states: IDLE and BUSY; a 1-bit grant register and a 1-bit last-grant register hold the arbitration context.
REQ-014 In IDLE a source is requesting when its tvalid=1 and its src_en bit=1.
REQ-015 In IDLE with at least one requester, the block SHALL load grant and enter BUSY on the next edge (one-cycle arbitration latency).
REQ-016 With both sources requesting, the source not equal to last-grant SHALL win (round robin); a single requester always wins.
REQ-017 In IDLE all tready outputs and m00_axis_tvalid SHALL be 0.
REQ-018 In BUSY the granted source's tdata, tstrb, tvalid, tlast SHALL drive m00 combinationally; the granted source's tready = m00_axis_tready; the other source's tready = 0.
REQ-019 m00_axis_tdest SHALL equal grant in BUSY and 0 in IDLE.
REQ-020 On a granted beat with tvalid=1, tready=1, tlast=1 the FSM SHALL return to IDLE and set last-grant = grant.
REQ-021 Back-to-back frames SHALL be separated by exactly one idle cycle on m00.
REQ-022 Clearing src_en for the granted source mid-frame SHALL NOT abort the frame; it only blocks the next grant.
REQ-023 A source deasserting tvalid mid-frame SHALL stall m00 (m00_axis_tvalid=0) without releasing the grant.
REQ-024 busy SHALL be 1 exactly in state BUSY.

Reset
REQ-025 While aresetn=0: state=IDLE, grant=0, last-grant=1 (s00 wins first contention), all counters 0.
REQ-026 Reset asserted mid-frame SHALL immediately drop all tready and m00_axis_tvalid; the partial frame is abandoned with no recovery.

Configuration
REQ-027 Macro FRAME_ARB_STATS_EN defined: frame_cnt0/frame_cnt1 exist and increment by 1 on each forwarded tlast beat of their source, wrapping from 2^C_STAT_WIDTH-1 to 0.
REQ-028 Macro FRAME_ARB_STATS_EN undefined: counters and their ports are absent; all other behaviour is identical.

Structure
REQ-029 A shared package frame_arb_pkg SHALL hold the state enum (IDLE, BUSY) and the source index type.
REQ-030 A sub-module frame_arb_rr (2-way round-robin picker: requests and last-grant in, grant out) is natural and SHALL be used.

Verification
REQ-031 Both sources idle, src_en=11; s00 sends a 4-beat frame -> grant 0 one cycle later, 4 beats out, tdest=0, tlast on beat 4, then IDLE.
REQ-032 Both sources present a 3-beat frame simultaneously after reset -> s00 frame first, one idle cycle, then the s01 frame; then the next contention goes to s00.
REQ-033 m00_axis_tready toggles 1,0,1,0 during a frame -> no beat lost or duplicated; the ungranted tready stays 0.
REQ-034 src_en=01 and both sources valid -> only s00 is granted; setting src_en to 10 mid-frame completes the s00 frame, then s01 is granted.
REQ-035 aresetn pulsed low on beat 2 of 5 -> tvalid/tready drop the same cycle; after release the next contention is granted to s00.
REQ-036 With FRAME_ARB_STATS_EN and C_STAT_WIDTH=2, 5 frames from s01 -> frame_cnt1=1, frame_cnt0=0.
